// File: rtl/alu_issue_if.sv
// Operand/handshake bundle between the decode side, alu_issue and the ALU.
// A transfer happens on any rising clk edge where valid && ready are both high; valid never waits on ready.
interface alu_issue_if;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] instr;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        out_valid;
    logic        out_ready;
    logic [4:0]  opselect;
    logic [31:0] x;
    logic [31:0] y;
    logic [4:0]  shamt;
    logic [4:0]  dest;
    logic        wr_en;
    logic        ovf_chk;
    logic        illegal;
    logic [1:0]  state;

    modport master (
        output flush, in_valid, instr, rs_val, rt_val, out_ready,
        input  in_ready, out_valid, opselect, x, y, shamt, dest, wr_en, ovf_chk, illegal, state
    );

    modport slave (
        input  flush, in_valid, instr, rs_val, rt_val, out_ready,
        output in_ready, out_valid, opselect, x, y, shamt, dest, wr_en, ovf_chk, illegal, state
    );
endinterface

// File: rtl/alu_issue.sv
// MIPS decode + operand select into a flopped ALU issue buffer with stall and flush.
// ALU_ISSUE_SKID_EN selects a 2-entry skid buffer (registered in_ready); otherwise a single output register.
module alu_issue (
    input  logic  clk,
    input  logic  rst,
    alu_issue_if.slave bus
);
    typedef struct packed {
        logic [4:0]  opselect;
        logic [31:0] x;
        logic [31:0] y;
        logic [4:0]  shamt;
        logic [4:0]  dest;
        logic        wr_en;
        logic        ovf_chk;
        logic        illegal;
    } entry_t;

    typedef enum logic [1:0] {EMPTY = 2'd0, ONE = 2'd1, FULL = 2'd2} state_t;

    localparam logic [4:0] OP_ADD  = 5'b00000, OP_SUB = 5'b00001, OP_LTU = 5'b00010,
                           OP_SRAV = 5'b00011, OP_SLL = 5'b00100, OP_SLLV = 5'b00101,
                           OP_LT   = 5'b00111, OP_EQ  = 5'b01000, OP_AND = 5'b01001,
                           OP_OR   = 5'b01010, OP_SRA = 5'b01011, OP_NOR = 5'b01100,
                           OP_XOR  = 5'b01101, OP_SRLV = 5'b01110, OP_SRL = 5'b01111;

    state_t      state, state_nxt;
    entry_t      head, head_nxt, dec;
    logic        accept, pop, legal, shift_op;
    logic [5:0]  opcode, funct;
    logic [4:0]  rt_f, rd_f;
    logic [31:0] imm_se, imm_ze;

    assign opcode = bus.instr[31:26];
    assign funct  = bus.instr[5:0];
    assign rt_f   = bus.instr[20:16];
    assign rd_f   = bus.instr[15:11];
    assign imm_se = {{16{bus.instr[15]}}, bus.instr[15:0]};
    assign imm_ze = {16'b0, bus.instr[15:0]};

    // I-type fields are the defaults; R-type, lui and beq override what differs.
    always_comb begin
        dec       = '0;
        legal     = 1'b1;
        shift_op  = 1'b0;
        dec.x     = bus.rs_val;
        dec.y     = imm_se;
        dec.dest  = rt_f;
        dec.wr_en = 1'b1;
        case (opcode)
            6'h00: begin
                dec.y    = bus.rt_val;
                dec.dest = rd_f;
                case (funct)
                    6'h20: begin dec.opselect = OP_ADD; dec.ovf_chk = 1'b1; end
                    6'h21: dec.opselect = OP_ADD;
                    6'h22: begin dec.opselect = OP_SUB; dec.ovf_chk = 1'b1; end
                    6'h23: dec.opselect = OP_SUB;
                    6'h24: dec.opselect = OP_AND;
                    6'h25: dec.opselect = OP_OR;
                    6'h26: dec.opselect = OP_XOR;
                    6'h27: dec.opselect = OP_NOR;
                    6'h2A: dec.opselect = OP_LT;
                    6'h2B: dec.opselect = OP_LTU;
                    6'h00: begin dec.opselect = OP_SLL;  shift_op = 1'b1; end
                    6'h02: begin dec.opselect = OP_SRL;  shift_op = 1'b1; end
                    6'h03: begin dec.opselect = OP_SRA;  shift_op = 1'b1; end
                    6'h04: begin dec.opselect = OP_SLLV; shift_op = 1'b1; end
                    6'h06: begin dec.opselect = OP_SRLV; shift_op = 1'b1; end
                    6'h07: begin dec.opselect = OP_SRAV; shift_op = 1'b1; end
                    default: legal = 1'b0;
                endcase
                // Shifts operate on rt; rs supplies the variable shift count.
                if (shift_op) begin
                    dec.x     = bus.rt_val;
                    dec.y     = bus.rs_val;
                    dec.shamt = bus.instr[10:6];
                end
            end
            6'h08: begin dec.opselect = OP_ADD; dec.ovf_chk = 1'b1; end
            6'h09, 6'h23: dec.opselect = OP_ADD;
            6'h2B: begin dec.opselect = OP_ADD; dec.wr_en = 1'b0; end
            6'h0A: dec.opselect = OP_LT;
            6'h0B: dec.opselect = OP_LTU;
            6'h0C: begin dec.opselect = OP_AND; dec.y = imm_ze; end
            6'h0D: begin dec.opselect = OP_OR;  dec.y = imm_ze; end
            6'h0E: begin dec.opselect = OP_XOR; dec.y = imm_ze; end
            6'h0F: begin
                dec.opselect = OP_SLL;
                dec.x        = imm_ze;
                dec.y        = '0;
                dec.shamt    = 5'd16;
            end
            6'h04: begin
                dec.opselect = OP_EQ;
                dec.y        = bus.rt_val;
                dec.wr_en    = 1'b0;
                dec.dest     = '0;
            end
            default: legal = 1'b0;
        endcase
        if (!legal) dec = '0;
        dec.illegal = !legal;
    end

`ifdef ALU_ISSUE_SKID_EN
    entry_t tail, tail_nxt;
    assign bus.in_ready = (state != FULL);
`else
    assign bus.in_ready = (state == EMPTY) || bus.out_ready;
`endif

    assign bus.out_valid = (state != EMPTY);
    assign accept        = bus.in_valid && bus.in_ready && !bus.flush;
    assign pop           = bus.out_valid && bus.out_ready;

    always_comb begin
        state_nxt = state;
        head_nxt  = head;
`ifdef ALU_ISSUE_SKID_EN
        tail_nxt  = tail;
`endif
        case (state)
            EMPTY: if (accept) begin
                state_nxt = ONE;
                head_nxt  = dec;
            end
            ONE: begin
                if (accept && pop) head_nxt = dec;
`ifdef ALU_ISSUE_SKID_EN
                else if (accept) begin
                    state_nxt = FULL;
                    tail_nxt  = dec;
                end
`endif
                else if (pop) state_nxt = EMPTY;
            end
`ifdef ALU_ISSUE_SKID_EN
            FULL: if (pop) begin
                state_nxt = ONE;
                head_nxt  = tail;
            end
`endif
            default: state_nxt = EMPTY;
        endcase
        if (bus.flush) state_nxt = EMPTY;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= EMPTY;
            head  <= '0;
`ifdef ALU_ISSUE_SKID_EN
            tail  <= '0;
`endif
        end else begin
            state <= state_nxt;
            head  <= head_nxt;
`ifdef ALU_ISSUE_SKID_EN
            tail  <= tail_nxt;
`endif
        end
    end

    assign bus.opselect = head.opselect;
    assign bus.x        = head.x;
    assign bus.y        = head.y;
    assign bus.shamt    = head.shamt;
    assign bus.dest     = head.dest;
    assign bus.wr_en    = head.wr_en;
    assign bus.ovf_chk  = head.ovf_chk;
    assign bus.illegal  = head.illegal;
    assign bus.state    = state;
endmodule

// File: tb/tb_alu_issue.sv
// Bench for alu_issue: directed decode cases, stall/flush/reset scenarios and a randomized run
// checked against a queue model of the issue buffer and a table-driven MIPS decode reference.
module tb_alu_issue;
    logic clk = 1'b0;
    logic rst;
    alu_issue_if bus ();

    alu_issue dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

`ifdef ALU_ISSUE_SKID_EN
    localparam int CAP = 2;
`else
    localparam int CAP = 1;
`endif

    int checks = 0;
    int errors = 0;
    logic [81:0] exp_q[$];
    logic obs_rdy, exp_rdy;

    logic [5:0] op_tab [0:15] = '{6'h00, 6'h00, 6'h00, 6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C,
                                  6'h0D, 6'h0E, 6'h0F, 6'h04, 6'h23, 6'h2B, 6'h3F, 6'h02};
    logic [5:0] fn_tab [0:17] = '{6'h20, 6'h21, 6'h22, 6'h23, 6'h24, 6'h25, 6'h26, 6'h27, 6'h2A,
                                  6'h2B, 6'h00, 6'h02, 6'h03, 6'h04, 6'h06, 6'h07, 6'h3F, 6'h01};

    // Reference: {opselect, x, y, shamt, dest, wr_en, ovf_chk, illegal}
    function automatic logic [81:0] ref_decode(input logic [31:0] ins, input logic [31:0] rs,
                                               input logic [31:0] rt);
        logic [5:0] op, fn;
        logic [4:0] sel, sh, d;
        logic [31:0] a, b;
        logic we, ov, ok, is_shift;
        op = ins[31:26];
        fn = ins[5:0];
        sel = 5'b0; sh = 5'b0; d = 5'b0; a = 32'b0; b = 32'b0;
        we = 1'b0; ov = 1'b0; ok = 1'b1; is_shift = 1'b0;
        if (op == 6'h00) begin
            a = rs; b = rt; d = ins[15:11]; we = 1'b1;
            ov = (fn == 6'h20) || (fn == 6'h22);
            case (fn)
                6'h20, 6'h21: sel = 5'b00000;
                6'h22, 6'h23: sel = 5'b00001;
                6'h24: sel = 5'b01001;
                6'h25: sel = 5'b01010;
                6'h26: sel = 5'b01101;
                6'h27: sel = 5'b01100;
                6'h2A: sel = 5'b00111;
                6'h2B: sel = 5'b00010;
                6'h00: begin sel = 5'b00100; is_shift = 1'b1; end
                6'h02: begin sel = 5'b01111; is_shift = 1'b1; end
                6'h03: begin sel = 5'b01011; is_shift = 1'b1; end
                6'h04: begin sel = 5'b00101; is_shift = 1'b1; end
                6'h06: begin sel = 5'b01110; is_shift = 1'b1; end
                6'h07: begin sel = 5'b00011; is_shift = 1'b1; end
                default: ok = 1'b0;
            endcase
            if (is_shift) begin a = rt; b = rs; sh = ins[10:6]; end
        end else begin
            a = rs; d = ins[20:16]; we = (op != 6'h2B); ov = (op == 6'h08);
            b = {{16{ins[15]}}, ins[15:0]};
            case (op)
                6'h08, 6'h09, 6'h23, 6'h2B: sel = 5'b00000;
                6'h0A: sel = 5'b00111;
                6'h0B: sel = 5'b00010;
                6'h0C: begin sel = 5'b01001; b = {16'b0, ins[15:0]}; end
                6'h0D: begin sel = 5'b01010; b = {16'b0, ins[15:0]}; end
                6'h0E: begin sel = 5'b01101; b = {16'b0, ins[15:0]}; end
                6'h0F: begin sel = 5'b00100; a = {16'b0, ins[15:0]}; b = 32'b0; sh = 5'd16; end
                6'h04: begin sel = 5'b01000; b = rt; we = 1'b0; d = 5'b0; end
                default: ok = 1'b0;
            endcase
        end
        if (!ok) return {81'b0, 1'b1};
        return {sel, a, b, sh, d, we, ov, 1'b0};
    endfunction

    function automatic logic [81:0] dut_out();
        return {bus.opselect, bus.x, bus.y, bus.shamt, bus.dest, bus.wr_en, bus.ovf_chk, bus.illegal};
    endfunction

    function automatic logic [31:0] rand_instr();
        logic [31:0] ins;
        ins = $urandom();
        ins[31:26] = op_tab[$urandom_range(0, 15)];
        if (ins[31:26] == 6'h00) ins[5:0] = fn_tab[$urandom_range(0, 17)];
        return ins;
    endfunction

    // Driver: called at a negedge; drives one cycle and advances the model at the posedge.
    task automatic cycle(input logic fl, input logic v, input logic [31:0] ins,
                         input logic [31:0] rs, input logic [31:0] rt, input logic ordy);
        logic acc, pp;
        bus.flush = fl; bus.in_valid = v; bus.instr = ins;
        bus.rs_val = rs; bus.rt_val = rt; bus.out_ready = ordy;
        #1;
        exp_rdy = (CAP == 2) ? (exp_q.size() < 2) : (exp_q.size() == 0 || ordy);
        obs_rdy = bus.in_ready;
        acc = v && exp_rdy && !fl;
        pp  = (exp_q.size() > 0) && ordy;
        @(posedge clk);
        if (pp) void'(exp_q.pop_front());
        if (fl) exp_q.delete();
        if (acc) exp_q.push_back(ref_decode(ins, rs, rt));
        @(negedge clk);
    endtask

    task automatic test_reset();
        bus.flush = 0; bus.in_valid = 0; bus.instr = 0; bus.rs_val = 0; bus.rt_val = 0; bus.out_ready = 0;
        rst = 1'b1;
        #3;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (dut_out() !== 82'b0) begin errors++; $display("FAIL reset_data: got %h want 0", dut_out()); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready: got %b want 1", bus.in_ready); end
        @(negedge clk);
        rst = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_directed();
        logic [31:0] ins_tab [0:7] = '{32'h00221820, 32'h000220C3, 32'h2025FFFF, 32'h3025FFFF,
                                       32'hFC000000, 32'h3C07ABCD, 32'h10430010, 32'hAC45FFF0};
        logic [31:0] rs_tab [0:7]  = '{32'd5, 32'd0, 32'd10, 32'h12345678, 32'd1, 32'd2, 32'd9, 32'd100};
        logic [31:0] rt_tab [0:7]  = '{32'd7, 32'h80000000, 32'd3, 32'd4, 32'd2, 32'd3, 32'd9, 32'd5};
        logic [81:0] fixed [0:4];
        fixed[0] = {5'b00000, 32'd5, 32'd7, 5'd0, 5'd3, 1'b1, 1'b1, 1'b0};
        fixed[1] = {5'b01011, 32'h80000000, 32'd0, 5'd3, 5'd4, 1'b1, 1'b0, 1'b0};
        fixed[2] = {5'b00000, 32'd10, 32'hFFFFFFFF, 5'd0, 5'd5, 1'b1, 1'b1, 1'b0};
        fixed[3] = {5'b01001, 32'h12345678, 32'h0000FFFF, 5'd0, 5'd5, 1'b1, 1'b0, 1'b0};
        fixed[4] = {81'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            cycle(1'b0, 1'b1, ins_tab[i], rs_tab[i], rt_tab[i], 1'b1);
            checks++;
            if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL dir_valid[%0d]: got %b want 1", i, bus.out_valid); end
            checks++;
            if (exp_q.size() == 0 || dut_out() !== exp_q[0]) begin
                errors++; $display("FAIL dir_model[%0d]: got %h want %h", i, dut_out(), exp_q.size() ? exp_q[0] : 82'b0);
            end
            if (i < 5) begin
                checks++;
                if (dut_out() !== fixed[i]) begin errors++; $display("FAIL dir_fixed[%0d]: got %h want %h", i, dut_out(), fixed[i]); end
            end
        end
        cycle(1'b0, 1'b0, 32'b0, 32'b0, 32'b0, 1'b1);
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL dir_drain: got %b want 0", bus.out_valid); end
    endtask

    task automatic test_back_pressure();
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b1, rand_instr(), $urandom(), $urandom(), 1'b0);
            checks++;
            if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL bp_in_ready[%0d]: got %b want %b", i, obs_rdy, exp_rdy); end
        end
        checks++;
        if (bus.in_ready !== (CAP == 1 ? 1'b0 : 1'b0)) begin errors++; $display("FAIL bp_full: in_ready %b want 0", bus.in_ready); end
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, 1'b0, 32'b0, 32'b0, 32'b0, 1'b0);
            checks++;
            if (exp_q.size() == 0 || dut_out() !== exp_q[0]) begin errors++; $display("FAIL bp_stable[%0d]: got %h", i, dut_out()); end
        end
        for (int i = 0; i < CAP + 1; i++) begin
            checks++;
            if (bus.out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL bp_drain_valid[%0d]: got %b want %b", i, bus.out_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                checks++;
                if (dut_out() !== exp_q[0]) begin errors++; $display("FAIL bp_order[%0d]: got %h want %h", i, dut_out(), exp_q[0]); end
            end
            cycle(1'b0, 1'b0, 32'b0, 32'b0, 32'b0, 1'b1);
        end
    endtask

    task automatic test_flush();
        logic [31:0] ins;
        for (int i = 0; i < CAP; i++) cycle(1'b0, 1'b1, rand_instr(), $urandom(), $urandom(), 1'b0);
        cycle(1'b1, 1'b1, 32'h00221820, 32'd1, 32'd2, 1'($urandom_range(0, 1)));
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL flush_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL flush_in_ready: got %b want 1", bus.in_ready); end
        ins = $urandom();
        ins[31:26] = 6'h3F;
        cycle(1'b0, 1'b1, ins, $urandom(), $urandom(), 1'b0);
        checks++;
        if ({bus.out_valid, bus.illegal, bus.wr_en} !== 3'b110) begin
            errors++; $display("FAIL illegal_op: valid/illegal/wr_en got %b want 110", {bus.out_valid, bus.illegal, bus.wr_en});
        end
        cycle(1'b0, 1'b0, 32'b0, 32'b0, 32'b0, 1'b1);
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            cycle(1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 3) != 0), rand_instr(),
                  $urandom(), $urandom(), 1'($urandom_range(0, 2) != 0));
            checks++;
            if (obs_rdy !== exp_rdy) begin errors++; $display("FAIL rnd_in_ready[%0d]: got %b want %b", i, obs_rdy, exp_rdy); end
            checks++;
            if (bus.out_valid !== (exp_q.size() > 0)) begin errors++; $display("FAIL rnd_valid[%0d]: got %b want %b", i, bus.out_valid, exp_q.size() > 0); end
            if (exp_q.size() > 0) begin
                checks++;
                if (dut_out() !== exp_q[0]) begin errors++; $display("FAIL rnd_data[%0d]: got %h want %h", i, dut_out(), exp_q[0]); end
            end
        end
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < CAP; i++) cycle(1'b0, 1'b1, rand_instr(), $urandom(), $urandom(), 1'b0);
        bus.in_valid = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL mid_reset_valid: got %b want 0", bus.out_valid); end
        checks++;
        if (dut_out() !== 82'b0) begin errors++; $display("FAIL mid_reset_data: got %h want 0", dut_out()); end
        checks++;
        if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL mid_reset_in_ready: got %b want 1", bus.in_ready); end
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        cycle(1'b0, 1'b1, 32'h00221820, 32'd5, 32'd7, 1'b1);
        checks++;
        if (exp_q.size() == 0 || dut_out() !== exp_q[0]) begin errors++; $display("FAIL post_reset_issue: got %h", dut_out()); end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_pressure();
        test_flush();
        test_random();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/alu_issue.md
# alu_issue

Execute-stage issue register that sits on the operand side of the `alu` block. It accepts a raw MIPS instruction with its register-file operand values and decodes `opcode`/`funct` into the 5-bit ALU `opselect`. It also selects `x`/`y`/`shamt` operands and buffers the result behind a valid/ready handshake, so the ALU input is always driven from flops. It supports pipeline stall (back-pressure) and flush.

## Interface
- No parameters; widths fixed (32-bit datapath, 5-bit opselect).
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-high reset.
- `flush`  in  1  discard all buffered entries and any same-cycle input.
- `in_valid`  in  1  instruction/operands valid.
- `in_ready`  out  1  block can accept this cycle.
- `instr`  in  32  MIPS instruction word.
- `rs_val`, `rt_val`  in  32 each  register-file values of rs/rt.
- `out_valid`  out  1  ALU operands valid.
- `out_ready`  in  1  downstream consumes this cycle.
- `opselect`  out  5  ALU operation code.
- `x`, `y`  out  32 each  ALU operands.
- `shamt`  out  5  shift amount.
- `dest`  out  5  writeback register (rd for R-type, rt for I-type, 0 if none).
- `wr_en`  out  1  result is written back.
- `ovf_chk`  out  1  overflow trap enabled for this op (add/sub/addi).
- `illegal`  out  1  opcode/funct not decoded.

## Operation
- Opselect codes: add 00000, sub 00001, ltu 00010, sra-by-y 00011, sll-by-shamt 00100, sll-by-y 00101, lt 00111, eq 01000, and 01001, or 01010, sra-by-shamt 01011, nor 01100, xor 01101, srl-by-y 01110, srl-by-shamt 01111.
- R-type (opcode 0): funct 0x20/0x21→add, 0x22/0x23→sub, 0x24→and, 0x25→or, 0x26→xor, 0x27→nor, 0x2A→lt, 0x2B→ltu; x=rs_val, y=rt_val, dest=rd.
- R-type shifts: 0x00→00100, 0x02→01111, 0x03→01011, 0x04→00101, 0x06→01110, 0x07→00011; x=rt_val, y=rs_val (low 5 bits significant), shamt=instr[10:6], dest=rd.
- I-type, x=rs_val, dest=rt:
  - addi 0x08 / addiu 0x09 → add, sign-extended imm.
  - slti 0x0A → lt, sign-extended imm.
  - sltiu 0x0B → ltu, sign-extended imm.
  - andi 0x0C / ori 0x0D / xori 0x0E → and / or / xor, zero-extended imm.
  - lw 0x23 / sw 0x2B → add, sign-extended imm. sw has wr_en=0.
- lui 0x0F: opselect 00100, x={16'b0,imm}, y=0, shamt=16.
- beq 0x04: opselect eq, x=rs_val, y=rt_val, wr_en=0, dest=0.
- ovf_chk=1 only for funct 0x20, 0x22 and opcode 0x08.
- Anything else: illegal=1, opselect 00000, wr_en=0, dest=0, x=y=0.
- Buffer: 2-entry skid; entry 0 drives outputs.
  - States: EMPTY, ONE, FULL.
  - Accept when in_valid&&in_ready. Pop when out_valid&&out_ready.
  - Simultaneous accept and pop in ONE: stays ONE, new data replaces head.
- flush: next state EMPTY; same-cycle accept dropped; same-cycle pop still counts upstream.

## Timing
- Reset (async assert): out_valid=0, all data outputs 0, in_ready=1, state EMPTY.
- Reset release is synchronous to `clk`.
- Latency: accepted instruction appears on outputs next cycle (1 cycle).
- in_ready is registered: in_ready = (state != FULL). No combinational path from out_ready to in_ready.
- Throughput: 1 instruction/cycle while out_ready=1.
- Output data is stable while out_valid && !out_ready.
- Reset mid-operation: all entries lost immediately; outputs return to reset values asynchronously.

## Configuration
- `ALU_ISSUE_SKID_EN` defined: 2-entry skid buffer as above; in_ready registered.
- Not defined: single output register.
  - in_ready = !out_valid || out_ready (combinational).
  - Same 1-cycle latency and full throughput; states EMPTY/ONE only.
  - flush and reset behaviour unchanged.

## Test plan
- Reset asserted mid-stream with two entries held → out_valid=0, outputs 0, in_ready=1 in the same cycle (before the next clock edge).
- `add $3,$1,$2` (0x00221820), rs=5, rt=7, out_ready=1 → next cycle opselect=00000, x=5, y=7, dest=3, wr_en=1, ovf_chk=1.
- `sra $4,$2,3` (0x000220C3), rt=0x80000000 → opselect=01011, x=0x80000000, shamt=3, dest=4.
- `addi $5,$1,-1` (0x2025FFFF), rs=10 → opselect=00000, y=0xFFFFFFFF, dest=5. `andi` with imm 0xFFFF → y=0x0000FFFF.
- Back-pressure: out_ready=0, push three valid instrs → two accepted, in_ready=0 after the second. Release out_ready → both emerge in order, unchanged.
- flush in FULL state with in_valid=1 → next cycle out_valid=0, in_ready=1. Opcode 0x3F → illegal=1, wr_en=0.
